// File: rtl/turf_event_fragmenter_pkg.sv
// Shared types and constants for the event fragmenter: FSM states, tag layout, UDP sizes.
package turf_event_fragmenter_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFragHdr,
    StFragTag,
    StFragData,
    StHoldoff,
    StDump,
    StStopped
  } state_e;

  // UDP header is 8 bytes; every fragment also carries one 8-byte tag qword.
  localparam int unsigned UDP_HDR_BYTES = 8;
  localparam int unsigned TAG_BYTES     = 8;

  // Tag qword layout: {event_number, frag_index, last, frag_qwords[14:0]}.
  localparam int unsigned TAG_EVNUM_MSB = 63;
  localparam int unsigned TAG_EVNUM_LSB = 32;
  localparam int unsigned TAG_IDX_MSB   = 31;
  localparam int unsigned TAG_IDX_LSB   = 16;
  localparam int unsigned TAG_LAST_BIT  = 15;
  localparam int unsigned TAG_QW_MSB    = 14;
  localparam int unsigned TAG_QW_LSB    = 0;

  function automatic logic [63:0] make_tag(input logic [31:0] evnum, input logic [15:0] idx,
                                           input logic last, input logic [14:0] qwords);
    logic [63:0] tag;
    tag = '0;
    tag[TAG_EVNUM_MSB:TAG_EVNUM_LSB] = evnum;
    tag[TAG_IDX_MSB:TAG_IDX_LSB]     = idx;
    tag[TAG_LAST_BIT]                = last;
    tag[TAG_QW_MSB:TAG_QW_LSB]       = qwords;
    return tag;
  endfunction

endpackage

// File: rtl/turf_event_fragmenter.sv
// Splits length-prefixed events into UDP fragments: header, tag qword, then payload qwords.
module turf_event_fragmenter
  import turf_event_fragmenter_pkg::*;
#(
  parameter string       DEBUG      = "FALSE",
  parameter int unsigned EVNUM_BITS = 32
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [15:0] s_evlen_tdata,
  input  logic        s_evlen_tvalid,
  output logic        s_evlen_tready,
  input  logic [63:0] s_evdata_tdata,
  input  logic        s_evdata_tvalid,
  output logic        s_evdata_tready,
  output logic [63:0] m_udphdr_tdata,
  output logic        m_udphdr_tvalid,
  input  logic        m_udphdr_tready,
  output logic [63:0] m_udpdata_tdata,
  output logic [7:0]  m_udpdata_tkeep,
  output logic        m_udpdata_tlast,
  output logic        m_udpdata_tvalid,
  input  logic        m_udpdata_tready,
  input  logic [9:0]  nfragment_count_i,
  input  logic [31:0] fragment_holdoff_i,
  input  logic [31:0] event_ip_i,
  input  logic [15:0] event_port_i,
  input  logic        event_open_i,
  input  logic        emergency_stop_i,
  output logic        stopped_o
);

  state_e                  state_q, state_d;
  logic [EVNUM_BITS-1:0]   event_number_q, event_number_d;
  logic [16:0]             remaining_q, remaining_d;
  logic [15:0]             frag_index_q, frag_index_d;
  logic [31:0]             hold_cnt_q, hold_cnt_d;
  logic [9:0]              nfrag_q, nfrag_d;
  logic [31:0]             holdoff_q, holdoff_d;
  logic [31:0]             ip_q, ip_d;
  logic [15:0]             port_q, port_d;
  logic [10:0]             frag_left_q, frag_left_d;

  logic [16:0] nfrag_plus1;
  logic [16:0] frag_qwords;
  logic [19:0] udp_len_full;
  logic        frag_is_last;
  logic        holdoff_done;
  logic [31:0] evnum_32;

  // Fragment sizing; remaining only changes in FRAG_DATA, so this is stable in HDR/TAG.
  always_comb begin
    nfrag_plus1  = {7'd0, nfrag_q} + 17'd1;
    frag_qwords  = (remaining_q < nfrag_plus1) ? remaining_q : nfrag_plus1;
    udp_len_full = {frag_qwords, 3'b000} + 20'(UDP_HDR_BYTES + TAG_BYTES);
    frag_is_last = (remaining_q == frag_qwords);
    // A holdoff of 0 still spends one cycle in HOLDOFF.
    holdoff_done = ({1'b0, hold_cnt_q} + 33'd1) >= {1'b0, holdoff_q};
    evnum_32     = 32'(event_number_q);
  end

  // Next-state and output decode.
  always_comb begin
    state_d          = state_q;
    event_number_d   = event_number_q;
    remaining_d      = remaining_q;
    frag_index_d     = frag_index_q;
    hold_cnt_d       = hold_cnt_q;
    nfrag_d          = nfrag_q;
    holdoff_d        = holdoff_q;
    ip_d             = ip_q;
    port_d           = port_q;
    frag_left_d      = frag_left_q;
    s_evlen_tready   = 1'b0;
    s_evdata_tready  = 1'b0;
    m_udphdr_tdata   = '0;
    m_udphdr_tvalid  = 1'b0;
    m_udpdata_tdata  = '0;
    m_udpdata_tkeep  = '0;
    m_udpdata_tlast  = 1'b0;
    m_udpdata_tvalid = 1'b0;
    stopped_o        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (emergency_stop_i) begin
          state_d = StStopped;
        end else begin
          s_evlen_tready = 1'b1;
          if (s_evlen_tvalid) begin
            remaining_d = {1'b0, s_evlen_tdata};
            state_d     = StLoad;
          end
        end
      end

      StLoad: begin
        nfrag_d      = nfragment_count_i;
        holdoff_d    = fragment_holdoff_i;
        ip_d         = event_ip_i;
        port_d       = event_port_i;
        frag_index_d = '0;
        hold_cnt_d   = '0;
        // A zero-length event is routed through DUMP, which exits immediately.
        if (!event_open_i || emergency_stop_i || (remaining_q == '0)) begin
          state_d = StDump;
        end else begin
          state_d = StFragHdr;
        end
      end

      StFragHdr: begin
        m_udphdr_tvalid = 1'b1;
        m_udphdr_tdata  = {ip_q, port_q, udp_len_full[15:0]};
        if (m_udphdr_tready) state_d = StFragTag;
      end

      StFragTag: begin
        m_udpdata_tvalid = 1'b1;
        m_udpdata_tkeep  = 8'hFF;
        m_udpdata_tdata  = make_tag(evnum_32, frag_index_q, frag_is_last, frag_qwords[14:0]);
        if (m_udpdata_tready) begin
          frag_left_d = frag_qwords[10:0];
          state_d     = StFragData;
        end
      end

      StFragData: begin
        m_udpdata_tvalid = s_evdata_tvalid;
        m_udpdata_tdata  = s_evdata_tdata;
        m_udpdata_tkeep  = 8'hFF;
        m_udpdata_tlast  = (frag_left_q == 11'd1);
        s_evdata_tready  = m_udpdata_tready;
        if (s_evdata_tvalid && m_udpdata_tready) begin
          remaining_d = remaining_q - 17'd1;
          frag_left_d = frag_left_q - 11'd1;
          if (frag_left_q == 11'd1) begin
            if (remaining_q == 17'd1) begin
              event_number_d = event_number_q + EVNUM_BITS'(1);
              state_d        = StIdle;
            end else begin
              frag_index_d = frag_index_q + 16'd1;
              hold_cnt_d   = '0;
              state_d      = StHoldoff;
            end
          end
        end
      end

      StHoldoff: begin
        if (holdoff_done) begin
          state_d = emergency_stop_i ? StDump : StFragHdr;
        end else begin
          hold_cnt_d = hold_cnt_q + 32'd1;
        end
      end

      StDump: begin
        s_evdata_tready = 1'b1;
        if (remaining_q == '0) begin
          state_d = emergency_stop_i ? StStopped : StIdle;
        end else if (s_evdata_tvalid) begin
          remaining_d = remaining_q - 17'd1;
          if (remaining_q == 17'd1) state_d = emergency_stop_i ? StStopped : StIdle;
        end
      end

      StStopped: begin
        stopped_o = 1'b1;
        if (!emergency_stop_i) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  // State and per-event context registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q        <= StIdle;
      event_number_q <= '0;
      remaining_q    <= '0;
      frag_index_q   <= '0;
      hold_cnt_q     <= '0;
      nfrag_q        <= '0;
      holdoff_q      <= '0;
      ip_q           <= '0;
      port_q         <= '0;
      frag_left_q    <= '0;
    end else begin
      state_q        <= state_d;
      event_number_q <= event_number_d;
      remaining_q    <= remaining_d;
      frag_index_q   <= frag_index_d;
      hold_cnt_q     <= hold_cnt_d;
      nfrag_q        <= nfrag_d;
      holdoff_q      <= holdoff_d;
      ip_q           <= ip_d;
      port_q         <= port_d;
      frag_left_q    <= frag_left_d;
    end
  end

  // Probe bundle for the event_frag_ila core, picked up by the implementation flow.
  if (DEBUG == "TRUE") begin : event_frag_ila
    (* mark_debug = "true" *) logic [2:0] dbg_state;
    (* mark_debug = "true" *) logic [3:0] dbg_handshakes;
    assign dbg_state      = state_q;
    assign dbg_handshakes = {m_udphdr_tvalid, m_udphdr_tready, m_udpdata_tvalid, m_udpdata_tready};
  end

endmodule
